// File: rtl/q2b_motor_responder.sv
// Motor-side responder for the q2b start-up handshake: preamble, 1,0,1 qualification, delayed y.
// Define Q2B_RESP_CHECK_EN to build the protocol checker that drives proto_err.
module q2b_motor_responder #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned OBS_LEN = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       f,
  input  logic       g,
  input  logic [3:0] pre_len,
  input  logic [1:0] y_dly,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic       proto_err
);

  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam int unsigned ObsW = $clog2(OBS_LEN + 1);
  // One shared counter wide enough for the 4-bit preamble and both parameters.
  localparam int unsigned CntW = (ToW > ObsW) ? ((ToW > 4) ? ToW : 4)
                                              : ((ObsW > 4) ? ObsW : 4);
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] ObsLast = CntW'(OBS_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StPre, StSeq1, StSeq0, StSeq2, StWaitG, StResp, StHold, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        pre_len_q, pre_len_d;
  logic [1:0]        y_dly_q, y_dly_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              start;
  logic              busy_st;
  logic [3:0]        pre_last;
  logic [1:0]        dly_last;

  assign busy_st  = (state_q != StIdle) && (state_q != StDone);
  assign pre_last = pre_len_q - 4'd1;
  assign dly_last = y_dly_q - 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    pre_len_d = pre_len_q;
    y_dly_d   = y_dly_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    start     = 1'b0;

    case (state_q)
      StIdle:  start = f;
      StPre:   if (cnt_q == CntW'(pre_last)) state_d = StSeq1;
      StSeq1:  state_d = StSeq0;
      StSeq0:  state_d = StSeq2;
      StSeq2: begin
        state_d = StWaitG;
        cnt_d   = '0;
      end
      StWaitG: begin
        if (g) begin
          cnt_d   = '0;
          state_d = (y_dly_q == 2'd0) ? StHold : StResp;
        end else if (cnt_q == ToLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StResp: begin
        if (!g) begin
          state_d = StDone;
        end else if (cnt_q == CntW'(dly_last)) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (!g) begin
          state_d = StDone;
        end else if (cnt_q == ObsLast) begin
          state_d = StDone;
          pass_d  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start pulse mid-run aborts and relaunches exactly as from idle.
    if (f && busy_st) start = 1'b1;

    if (start) begin
      pre_len_d = pre_len;
      y_dly_d   = y_dly;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = '0;
      state_d   = (pre_len == 4'd0) ? StSeq1 : StPre;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pre_len_q <= '0;
      y_dly_q   <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_len_q <= pre_len_d;
      y_dly_q   <= y_dly_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef Q2B_RESP_CHECK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q;
    if (start) proto_err_d = busy_st;
    if (g && (state_q inside {StPre, StSeq1, StSeq0, StSeq2})) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) proto_err_q <= 1'b0;
    else         proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

  assign x       = (state_q == StSeq1) || (state_q == StSeq2);
  assign y       = (state_q == StHold);
  assign busy    = busy_st;
  assign done    = (state_q == StDone);
  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_q2b_motor_responder.sv
// Directed bench for q2b_motor_responder; outputs checked as {x,y,busy,done,pass,timeout,proto_err}.
module tb_q2b_motor_responder;

`ifdef Q2B_RESP_CHECK_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn, f, g;
  logic [3:0] pre_len;
  logic [1:0] y_dly;
  logic       x, y, busy, done, pass, timeout, proto_err;
  int         vectors = 0;
  int         miscompares = 0;

  q2b_motor_responder #(.TIMEOUT(8), .OBS_LEN(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .f         (f),
    .g         (g),
    .pre_len   (pre_len),
    .y_dly     (y_dly),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {x, y, busy, done, pass, timeout, proto_err};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; f = 1'b0; g = 1'b0; pre_len = 4'd0; y_dly = 2'd0;
    step(); step();
    chk("reset", 7'b0000000);
    resetn = 1'b1;
    step();
    chk("idle", 7'b0000000);

    // Scenario 1: pre_len=0, y_dly=0, lock held.
    f = 1'b1;
    step(); f = 1'b0;
    chk("s1_seq1", 7'b1010000);
    step(); chk("s1_seq0", 7'b0010000);
    step(); chk("s1_seq2", 7'b1010000);
    step(); chk("s1_waitg", 7'b0010000);
    g = 1'b1;
    step(); chk("s1_hold0", 7'b0110000);
    for (int i = 0; i < 3; i++) begin
      step(); chk("s1_hold", 7'b0110000);
    end
    step(); chk("s1_done", 7'b0001100);
    g = 1'b0;
    step(); chk("s1_idle_pass", 7'b0000100);

    // Scenario 2: pre_len=3 preamble.
    pre_len = 4'd3; f = 1'b1;
    step(); f = 1'b0; pre_len = 4'd0;
    chk("s2_pre0", 7'b0010000);
    for (int i = 0; i < 2; i++) begin
      step(); chk("s2_pre", 7'b0010000);
    end
    step(); chk("s2_seq1", 7'b1010000);
    step(); chk("s2_seq0", 7'b0010000);
    step(); chk("s2_seq2", 7'b1010000);
    step(); chk("s2_waitg", 7'b0010000);
    g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); chk("s2_hold", 7'b0110000);
    end
    step(); chk("s2_done", 7'b0001100);
    g = 1'b0;
    step(); chk("s2_idle", 7'b0000100);

    // Scenario 3: y_dly=1, g drops once y is up.
    y_dly = 2'd1; f = 1'b1;
    step(); f = 1'b0; y_dly = 2'd0;
    chk("s3_seq1", 7'b1010000);
    step(); step();
    step(); chk("s3_waitg", 7'b0010000);
    g = 1'b1;
    step(); chk("s3_resp", 7'b0010000);
    step(); chk("s3_hold", 7'b0110000);
    g = 1'b0;
    step(); chk("s3_done_fail", 7'b0001000);
    step(); chk("s3_idle", 7'b0000000);

    // Scenario 4: no grant -> timeout after 8 WAIT_G cycles.
    f = 1'b1;
    step(); f = 1'b0;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      step(); chk("s4_waitg", 7'b0010000);
    end
    step(); chk("s4_done_to", 7'b0001010);
    step(); chk("s4_idle_to", 7'b0000010);

    // Scenario 5: restart during SEQ0 with a new preamble length.
    pre_len = 4'd2; f = 1'b1;
    step(); f = 1'b0;
    chk("s5_pre0", 7'b0010000);
    step(); chk("s5_pre1", 7'b0010000);
    step(); chk("s5_seq1", 7'b1010000);
    step(); chk("s5_seq0", 7'b0010000);
    pre_len = 4'd1; f = 1'b1;
    step(); f = 1'b0; pre_len = 4'd0;
    chk("s5_restart_pre", {6'b001000, PE});
    step(); chk("s5_seq1b", {6'b101000, PE});
    step(); chk("s5_seq0b", {6'b001000, PE});
    step(); chk("s5_seq2b", {6'b101000, PE});
    step(); chk("s5_waitg", {6'b001000, PE});
    g = 1'b1;
    step(); chk("s5_hold", {6'b011000, PE});

    // Scenario 6: reset asserted during HOLD.
    resetn = 1'b0;
    step(); chk("s6_reset_hold", 7'b0000000);
    g = 1'b0; resetn = 1'b1;
    step(); chk("s6_idle", 7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/q2b_motor_responder.md
# q2b_motor_responder

Motor-side responder for the q2b start-up handshake, the peer of the handshake controller. After the controller's one-cycle `f` start pulse, it drives the `x` status line with a configurable idle preamble followed by the 1,0,1 qualification sequence. It then waits for `g`, answers on `y` after a programmable delay, and reports whether `g` stayed asserted (lock) or dropped (rejected). It sits in the motor model / test harness and is also used as the bring-up stimulus for the controller.

## Interface
- `TIMEOUT`, default 8: max WAIT_G cycles without `g` before timeout.
- `OBS_LEN`, default 4: cycles `g` is monitored after `y` rises.
- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  reset. Synchronous, active-low. Clock is `clk`.
- `f`  in  1  start pulse from controller.
- `g`  in  1  grant from controller.
- `pre_len`  in  4  preamble length (x=0 cycles), sampled on the `f` edge.
- `y_dly`  in  2  response delay, sampled on the `f` edge.
- `x`  out  1  status line to controller.
- `y`  out  1  response line to controller.
- `busy`  out  1  high in any state other than IDLE/DONE.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  sticky result: lock held, valid from `done` until next run.
- `timeout`  out  1  sticky: no `g` within TIMEOUT.
- `proto_err`  out  1  sticky protocol violation (see Configuration).

## Operation
- States: IDLE, PRE, SEQ1, SEQ0, SEQ2, WAIT_G, RESP, HOLD, DONE. All outputs are decoded from registered state/flags (Moore).
- IDLE: x=0, y=0. Sampled f=1 → latch `pre_len`/`y_dly`, clear `pass`/`timeout`/`proto_err`, go to PRE (pre_len>0) or SEQ1 (pre_len=0).
- PRE: x=0 for exactly pre_len cycles, then SEQ1.
- SEQ1: x=1. SEQ0: x=0. SEQ2: x=1. Each lasts one cycle, in that order.
- WAIT_G: x=0, cycle counter from 0.
  - g sampled 1 → RESP, or HOLD if y_dly=0.
  - counter reaches TIMEOUT → DONE with timeout=1, pass=0.
- RESP: y=0 for y_dly cycles, then HOLD.
- HOLD: y=1 for OBS_LEN cycles. After that → DONE with pass=1.
- Failure: g sampled 0 at any edge in RESP or HOLD → DONE with pass=0.
- DONE: done=1 for one cycle, x=0, y=0, then IDLE. pass/timeout/proto_err hold until the next accepted `f`.
- f sampled 1 in any state other than IDLE/DONE: abort and restart as from IDLE, relatching inputs.
- Counters are saturating and sized by $clog2 of their parameters. TIMEOUT≥1 and OBS_LEN≥1 are required.

## Timing
- Reset: state IDLE; x, y, busy, done, pass, timeout, proto_err all 0. resetn low mid-run overrides everything on that edge.
- Edge e0 samples f=1. The first preamble cycle (or x=1 when pre_len=0) is the cycle after e0.
- Against the controller, which is in B during the f cycle and in S0 after e0: with pre_len=0, x reads 1,0,1 over the three cycles after e0. The controller then asserts g in the fourth cycle.
- Edge k samples g=1 first. y=1 begins in the cycle after edge k+y_dly.
- The controller requires y within two g-cycles, so y_dly=0 locks and y_dly≥1 is rejected.
- done rises on the edge that leaves HOLD, RESP or WAIT_G. pass is valid in the same cycle as done.

## Configuration
- `Q2B_RESP_CHECK_EN` defined: proto_err is set if either of these occurs:
  - g sampled 1 in PRE/SEQ1/SEQ0/SEQ2;
  - f sampled 1 while busy.
  The run continues per Operation.
- Not defined: checker logic is absent and proto_err is tied 0.

## Test plan
- Reset, then pre_len=0, y_dly=0, f pulse at e0, g=1 from e0+4 onward → x=1,0,1 in cycles e0+1..e0+3; y=1 from e0+5; done with pass=1, timeout=0 after OBS_LEN=4 cycles.
- pre_len=3, y_dly=0 → x=0 for 3 cycles, then 1,0,1; the rest follows scenario 1 delayed by 3 cycles.
- y_dly=1 with a controller-model g: g high for 2 cycles then low → y rises one cycle late; g=0 sampled → done with pass=0.
- g held 0 after the sequence → done after 8 WAIT_G cycles with timeout=1, pass=0.
- Second f pulse during SEQ0 → restart from the preamble. proto_err=1 only when `Q2B_RESP_CHECK_EN` is defined.
- resetn low during HOLD with y=1 → next cycle y=0, busy=0, pass=0, state IDLE.
